max_share_sched: RTL and testbench
==================================

MAX_SHARE_SCHED -- requirements
Module: max_share_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N_REQ, 4, number of requesters (power of two, 2..8).
REQ-002 The block SHALL have parameter IN_W, 10, operand width presented to the shared max datapath.
REQ-003 The block SHALL have parameter OUT_W, 4, result width returned by the shared max datapath.
REQ-004 The block SHALL have parameter SAMPLE_PERIOD, 16, exact-sampling interval; 0 disables exact sampling.
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, N_REQ, per-requester operand valid.
REQ-008 The block SHALL have port req_data, input, N_REQ*IN_W, operands; requester i at bits [i*IN_W +: IN_W].
REQ-009 The block SHALL have port req_ready, output, N_REQ, per-requester accept.
REQ-010 The block SHALL have port dp_in, output, IN_W, operand to the shared datapath.
REQ-011 The block SHALL have port dp_exact, output, 1, selects exact (1) or approximate (0) datapath.
REQ-012 The block SHALL have port dp_out, input, OUT_W, datapath result, combinational from dp_in/dp_exact.
REQ-013 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, OUT_W), rsp_id (output, log2 N_REQ), rsp_exact (output, 1): the single response channel.
REQ-014 The block SHALL have port busy, output, 1, high when any operation is in flight.

Function
REQ-015 The block SHALL have two stages: issue register A (operand, id, exact flag, a_valid) and response register B (result, id, exact flag, b_valid).
REQ-016 A SHALL drive dp_in/dp_exact from its contents when a_valid=1, and drive all-zero when a_valid=0.
REQ-017 B SHALL load dp_out, A.id and A.exact when a_valid=1 and (b_valid=0 or rsp_ready=1); otherwise B SHALL hold.
REQ-018 A SHALL accept when a_valid=0 or A moves to B in the same cycle; otherwise all req_ready SHALL be 0.
REQ-019 Arbitration SHALL be round-robin: the winner is the first asserted req_valid at or after pointer, ascending with wrap.
REQ-020 At most one req_ready bit SHALL be high, only for the winner; req_ready SHALL be combinational from req_valid and state.
REQ-021 The pointer SHALL become (winner+1) mod N_REQ only on a transfer (valid&ready); otherwise it SHALL hold.
REQ-022 A sample counter SHALL increment per transfer; the transfer is flagged exact when counter = SAMPLE_PERIOD-1, and the counter then wraps to 0.
REQ-023 SAMPLE_PERIOD=0 SHALL never flag exact; SAMPLE_PERIOD=1 SHALL flag every transfer exact.
REQ-024 Latency SHALL be 2 cycles: transfer at edge t -> rsp_valid=1 after edge t+1.
REQ-025 With rsp_ready held 1 and requests continuous, throughput SHALL be one response per cycle.
REQ-026 While rsp_valid=1 and rsp_ready=0, rsp_data/rsp_id/rsp_exact SHALL remain stable; no operation is dropped or reordered.
REQ-027 rsp_valid SHALL equal b_valid; busy SHALL equal a_valid | b_valid.
REQ-028 Requesters not granted SHALL see req_ready=0; the block does not require request stability, and a withdrawn request is simply not granted.

Reset
REQ-029 On rst_n=0, a_valid, b_valid, pointer and sample counter SHALL clear to 0 immediately, regardless of the clock.
REQ-030 During reset, req_ready, rsp_valid, rsp_data, rsp_id, rsp_exact, dp_in, dp_exact and busy SHALL all be 0; in-flight operations are discarded.

Verification
REQ-031 The bench SHALL cover single request: req_valid=4'b0100, data 10'h155, dp model out=4'hA -> rsp_valid 2 cycles later, rsp_data=4'hA, rsp_id=2.
REQ-032 The bench SHALL cover contention: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1..., one response per cycle, ids in the same order.
REQ-033 The bench SHALL cover backpressure: rsp_ready=0 for 3 cycles with A and B full -> response stable, req_ready=4'b0000, both ops delivered in order afterward.
REQ-034 The bench SHALL cover pointer wrap: pointer=2, req_valid=4'b1010 -> requester 3 first, pointer=0, then requester 1.
REQ-035 The bench SHALL cover sampling: SAMPLE_PERIOD=4, 8 transfers -> dp_exact and rsp_exact high only for transfers 4 and 8.
REQ-036 The bench SHALL cover mid-operation reset: rst_n low with A and B valid -> rsp_valid, busy, req_ready = 0 before the next edge; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/max_share_sched.sv
// Round-robin front end that time-shares one max datapath among N_REQ requesters.
// Issue stage A drives the datapath, response stage B holds the result for the consumer.
module max_share_sched #(
  parameter int N_REQ         = 4,
  parameter int IN_W          = 10,
  parameter int OUT_W         = 4,
  parameter int SAMPLE_PERIOD = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*IN_W-1:0]      req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [IN_W-1:0]            dp_in,
  output logic                       dp_exact,
  input  logic [OUT_W-1:0]           dp_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_W-1:0]           rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       rsp_exact,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (SAMPLE_PERIOD > 1) ? CNT_W'(SAMPLE_PERIOD - 1) : '0;

  logic [IN_W-1:0]  req_word [N_REQ];

  logic             a_valid_reg, a_valid_next;
  logic [IN_W-1:0]  a_data_reg, a_data_next;
  logic [ID_W-1:0]  a_id_reg, a_id_next;
  logic             a_exact_reg, a_exact_next;

  logic             b_valid_reg, b_valid_next;
  logic [OUT_W-1:0] b_data_reg, b_data_next;
  logic [ID_W-1:0]  b_id_reg, b_id_next;
  logic             b_exact_reg, b_exact_next;

  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             a_move;
  logic             a_accept;
  logic             xfer;
  logic             sample_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*IN_W +: IN_W];
      assign req_ready[gi] = xfer && (win_id == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or after the pointer; the index wraps because N_REQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_reg;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr_reg + ID_W'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign a_move     = a_valid_reg && (!b_valid_reg || rsp_ready);
  assign a_accept   = !a_valid_reg || a_move;
  // rst_n gating keeps req_ready low while reset is held, even though the state already reads idle.
  assign xfer       = rst_n && win_found && a_accept;
  assign sample_hit = (SAMPLE_PERIOD != 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    a_valid_next = a_valid_reg;
    a_data_next  = a_data_reg;
    a_id_next    = a_id_reg;
    a_exact_next = a_exact_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    if (xfer) begin
      a_valid_next = 1'b1;
      a_data_next  = req_word[win_id];
      a_id_next    = win_id;
      a_exact_next = sample_hit;
      ptr_next     = win_id + ID_W'(1);
      cnt_next     = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end else if (a_move) begin
      a_valid_next = 1'b0;
    end
  end

  always_comb begin
    b_valid_next = b_valid_reg;
    b_data_next  = b_data_reg;
    b_id_next    = b_id_reg;
    b_exact_next = b_exact_reg;
    if (a_move) begin
      b_valid_next = 1'b1;
      b_data_next  = dp_out;
      b_id_next    = a_id_reg;
      b_exact_next = a_exact_reg;
    end else if (b_valid_reg && rsp_ready) begin
      b_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_data_reg  <= '0;
      a_id_reg    <= '0;
      a_exact_reg <= 1'b0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      a_valid_reg <= a_valid_next;
      a_data_reg  <= a_data_next;
      a_id_reg    <= a_id_next;
      a_exact_reg <= a_exact_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_reg <= 1'b0;
      b_data_reg  <= '0;
      b_id_reg    <= '0;
      b_exact_reg <= 1'b0;
    end else begin
      b_valid_reg <= b_valid_next;
      b_data_reg  <= b_data_next;
      b_id_reg    <= b_id_next;
      b_exact_reg <= b_exact_next;
    end
  end

  assign dp_in     = a_valid_reg ? a_data_reg : '0;
  assign dp_exact  = a_valid_reg && a_exact_reg;
  assign rsp_valid = b_valid_reg;
  assign rsp_data  = b_data_reg;
  assign rsp_id    = b_id_reg;
  assign rsp_exact = b_exact_reg;
  assign busy      = a_valid_reg || b_valid_reg;

endmodule

// File: tb/tb_max_share_sched.sv
// Randomized and directed checks of max_share_sched against a transaction-level model
// (in-flight queue, round-robin pointer, transfer counter).
module tb_max_share_sched;
  localparam int N  = 4;
  localparam int IW = 10;
  localparam int OW = 4;
  localparam int SP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*IW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [IW-1:0] dp_in;
  logic          dp_exact;
  logic [OW-1:0] dp_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [OW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_exact;
  logic          busy;

  always #5 clk = ~clk;

  // Stand-in datapath: inverted low nibble, exact mode flips bit 0.
  assign dp_out = ~dp_in[OW-1:0] ^ {3'b000, dp_exact};

  max_share_sched #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dp_in(dp_in), .dp_exact(dp_exact), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_exact(rsp_exact), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [9:0] data;
    logic       exact;
    int         rdy;
  } op_t;

  op_t        q[$];
  int         ptr;
  int         cnt;
  int         cyc = 0;
  bit         last_xfer;
  logic [9:0] last_data;
  logic       last_exact;

  function automatic logic [3:0] dp_model(input logic [9:0] d, input logic ex);
    return ~d[3:0] ^ {3'b000, ex};
  endfunction

  task automatic model_reset();
    q.delete();
    ptr = 0;
    cnt = 0;
    last_xfer = 0;
  endtask

  task automatic cycle(input logic [3:0] v, input logic [39:0] d, input logic rr);
    int       win;
    bit       acc;
    bit       exp_rv;
    logic [3:0] exp_rdy;
    op_t      o;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && v[(ptr + k) % N]) win = (ptr + k) % N;
    // Two ops in flight fill both stages; a new one fits only if the head leaves now.
    acc     = (q.size() < 2) || rr;
    exp_rdy = (win >= 0 && acc) ? 4'(1 << win) : 4'b0000;
    exp_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, q.size() > 0);
    if (exp_rv) begin
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_data", rsp_data, dp_model(q[0].data, q[0].exact));
      check("rsp_exact", rsp_exact, q[0].exact);
    end
    if (last_xfer) begin
      check("dp_in", dp_in, last_data);
      check("dp_exact", dp_exact, last_exact);
    end
    @(posedge clk);
    cyc++;
    if (exp_rv && rr) begin
      $display("rsp id=%0d data=%h exact=%0b", q[0].id, rsp_data, q[0].exact);
      void'(q.pop_front());
    end
    last_xfer = 0;
    if (exp_rdy != 4'b0000) begin
      o.id    = win;
      o.data  = d[win*IW +: IW];
      o.exact = (cnt == SP - 1);
      o.rdy   = cyc + 1;
      cnt     = (cnt + 1) % SP;
      ptr     = (win + 1) % N;
      q.push_back(o);
      last_xfer  = 1;
      last_data  = o.data;
      last_exact = o.exact;
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    @(negedge clk);
    req_valid = v;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_data", rsp_data, 4'h0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_exact", rsp_exact, 1'b0);
    check("rst_dp_in", dp_in, 10'h000);
    check("rst_dp_exact", dp_exact, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  function automatic logic [39:0] rnd_data();
    return 40'({$urandom(), $urandom()});
  endfunction

  initial begin
    model_reset();
    do_reset(4'hF);

    // Single request from requester 2.
    cycle(4'b0100, {10'h000, 10'h155, 10'h000, 10'h000}, 1'b1);
    repeat (3) cycle(4'b0000, '0, 1'b1);

    // Contention, all four requesting with free output.
    do_reset(4'b0000);
    repeat (12) cycle(4'hF, rnd_data(), 1'b1);
    repeat (3) cycle(4'b0000, '0, 1'b1);

    // Backpressure with both stages full.
    do_reset(4'b0000);
    cycle(4'hF, rnd_data(), 1'b1);
    cycle(4'hF, rnd_data(), 1'b0);
    repeat (3) cycle(4'hF, rnd_data(), 1'b0);
    repeat (4) cycle(4'b0000, '0, 1'b1);

    // Pointer wrap from 2 with requesters 1 and 3.
    do_reset(4'b0000);
    cycle(4'b0010, rnd_data(), 1'b1);
    cycle(4'b1010, rnd_data(), 1'b1);
    cycle(4'b1010, rnd_data(), 1'b1);
    repeat (3) cycle(4'b0000, '0, 1'b1);

    // Sampling: eight transfers, exact on the 4th and 8th.
    do_reset(4'b0000);
    repeat (8) cycle(4'b0001, rnd_data(), 1'b1);
    repeat (3) cycle(4'b0000, '0, 1'b1);

    // Reset in the middle of operation, then the first grant goes to requester 0.
    cycle(4'hF, rnd_data(), 1'b0);
    cycle(4'hF, rnd_data(), 1'b0);
    do_reset(4'hF);
    cycle(4'hF, rnd_data(), 1'b1);
    repeat (3) cycle(4'b0000, '0, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom()), rnd_data(), ($urandom_range(0, 3) != 0));
    repeat (4) cycle(4'b0000, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
